synth_spi_rx: RTL



---
 rtl/protocol_pkg.sv | 48 ++++
 rtl/spi_sync.sv | 41 ++++
 rtl/synth_spi_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/protocol_pkg.sv
// Shared protocol definitions for the control-unit SPI link.
//   synth_t        : complete synthesizer parameter frame (480 bits, 60 bytes)
//   reset_synth_t  : value the synthesis core sees before any frame arrives
//   SPI_STATUS_*   : bit positions of the STATUS byte returned on MISO
package protocol_pkg;

  typedef struct packed {
    logic [31:0] rate;
    logic [31:0] duration;
  } envelope_t;

  typedef struct packed {
    logic [31:0] freq;
    logic [7:0]  shape;
    envelope_t   env;
  } wave_gen_t;

  // wave_gens[0] is the most significant generator; byte 0 on the wire is
  // the top byte of reverb.
  typedef struct packed {
    logic [31:0]     reverb;
    logic [31:0]     volume;
    wave_gen_t [0:3] wave_gens;
  } synth_t;

  // Silent generators, half volume, no reverb.
  localparam synth_t reset_synth_t =
    synth_t'({32'h0000_0000, 32'h4000_0000, {(4 * $bits(wave_gen_t)){1'b0}}});

  localparam int SPI_STATUS_VALID_BIT = 0;
  localparam int SPI_STATUS_ERR_BIT   = 1;
  localparam int SPI_STATUS_CNT_LSB   = 2;
  localparam int SPI_STATUS_CNT_W     = 8 - SPI_STATUS_CNT_LSB;

  function automatic logic [7:0] spi_status_byte(
    input logic                        last_valid,
    input logic                        last_err,
    input logic [SPI_STATUS_CNT_W-1:0] frame_cnt
  );
    logic [7:0] s;
    s = '0;
    s[SPI_STATUS_VALID_BIT] = last_valid;
    s[SPI_STATUS_ERR_BIT]   = last_err;
    s[SPI_STATUS_CNT_LSB +: SPI_STATUS_CNT_W] = frame_cnt;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by an
// edge-detect register.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   level_o  : synchronized level
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Everything resets to 0. For chip select this means the receiver only
  // leaves WAIT_IDLE after it has really observed the pin high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/synth_spi_rx.sv
// SPI mode-0 slave frame receiver, oversampled in the clk domain.
// Deserializes one synth_t per chip-select window (LSB first per byte,
// byte 0 = most significant) and commits it atomically to synth.
//   clk, rst    : system clock, synchronous active-high reset
//   sclk, mosi  : SPI clock / data in (asynchronous)
//   csel        : SPI chip select, active low (asynchronous)
//   miso        : STATUS byte, then echo of each received byte
//   synth       : last committed frame
//   frame_valid : one-cycle pulse when synth is updated
//   frame_err   : one-cycle pulse when a window is discarded
//   busy        : high while a window is being received
module synth_spi_rx
  import protocol_pkg::*;
#(
  parameter int FRAME_BYTES = $bits(synth_t) / 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   sclk,
  input  logic   mosi,
  input  logic   csel,
  output logic   miso,
  output synth_t synth,
  output logic   frame_valid,
  output logic   frame_err,
  output logic   busy
);

  localparam int SW         = $bits(synth_t);
  localparam int BYTE_CNT_W = $clog2(FRAME_BYTES + 2);
  localparam logic [BYTE_CNT_W-1:0] BYTES_FULL = BYTE_CNT_W'(FRAME_BYTES);
  localparam logic [BYTE_CNT_W-1:0] BYTES_SAT  = BYTE_CNT_W'(FRAME_BYTES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, COMMIT} state_e;

  state_e state_q, state_d;

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic csel_lvl, csel_rise, csel_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csel (
    .clk(clk), .rst(rst), .d_i(csel),
    .level_o(csel_lvl), .rise_o(csel_rise), .fall_o(csel_fall));

  // Only some synchronizer outputs are needed.
  logic sync_unused;
  assign sync_unused = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

  logic [2:0]            bit_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic [7:0]            byte_sr_q;
  logic [7:0]            tx_sr_q;
  logic                  miso_q;
  synth_t                stage_q;
  synth_t                synth_q;
  logic                  last_valid_q, last_err_q;
  logic [SPI_STATUS_CNT_W-1:0] frame_cnt_q;

  logic [7:0] byte_new;
  logic [7:0] status;
  logic       frame_good;

  assign byte_new   = {mosi_lvl, byte_sr_q[7:1]};
  assign status     = spi_status_byte(last_valid_q, last_err_q, frame_cnt_q);
  // Counters are frozen from the csel rise through COMMIT, so the same
  // test serves both the commit decision and the output pulses.
  assign frame_good = (byte_cnt_q == BYTES_FULL) && (bit_cnt_q == 3'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (csel_lvl)  state_d = IDLE;
      IDLE:      if (csel_fall) state_d = RECV;
      RECV:      if (csel_rise) state_d = COMMIT;
      COMMIT:                   state_d = IDLE;
      default:                  state_d = WAIT_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q == RECV);
    miso        = (state_q == RECV) & miso_q;
    frame_valid = (state_q == COMMIT) &  frame_good;
    frame_err   = (state_q == COMMIT) & ~frame_good;
  end

  assign synth = synth_q;

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_sr_q    <= '0;
      tx_sr_q      <= '0;
      miso_q       <= 1'b0;
      stage_q      <= reset_synth_t;
      synth_q      <= reset_synth_t;
      last_valid_q <= 1'b0;
      last_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csel_fall) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_sr_q    <= status;
            miso_q     <= status[0];
          end
        end
        RECV: begin
          if (csel_rise) begin
            // Commit is decided here so synth and frame_valid change together.
            if (frame_good) begin
              synth_q      <= stage_q;
              frame_cnt_q  <= frame_cnt_q + SPI_STATUS_CNT_W'(1);
              last_valid_q <= 1'b1;
              last_err_q   <= 1'b0;
            end else begin
              last_valid_q <= 1'b0;
              last_err_q   <= 1'b1;
            end
          end else if (sclk_rise) begin
            byte_sr_q <= byte_new;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q < BYTES_FULL) begin
                stage_q <= synth_t'({stage_q[SW-9:0], byte_new});
              end
              if (byte_cnt_q != BYTES_SAT) begin
                byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
              end
            end
          end else if (sclk_fall) begin
            // bit_cnt wrapped to 0: a byte just completed and byte_sr holds
            // it, so it becomes the next echo slot.
            if (bit_cnt_q == 3'd0) begin
              if (byte_cnt_q != '0) begin
                tx_sr_q <= byte_sr_q;
                miso_q  <= byte_sr_q[0];
              end
            end else begin
              miso_q <= tx_sr_q[bit_cnt_q];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
